fetch_pc_ctrl: RTL and testbench

//  Fetch sequencer owning the architectural PC: issues one instruction-memory read at a time and

---
 rtl/fetch_pc_ctrl_pkg.sv | 15 +
 rtl/fetch_hold_reg.sv | 34 +++
 rtl/fetch_pc_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared constants for the fetch sequencer: FSM state encodings, the reset
// instruction and the default boot address.
package fetch_pc_ctrl_pkg;

  localparam logic [1:0] ST_BOOT     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_reg.sv
// Instruction holding register presented to decode: loads a fetched word with
// its PC, and clears only the valid flag so the last pc/inst stay visible.
module fetch_hold_reg
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_inst,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst
);

  // Holding register: load has precedence, clear drops only the valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= NOP_INST;
    end else if (load) begin
      if_valid <= 1'b1;
      if_pc    <= load_pc;
      if_inst  <= load_inst;
    end else if (clear) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch sequencer owning the architectural PC: one outstanding imem read,
// redirects from execute kill wrong-path fetches, decode stalls hold output.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [31:0]     if_inst
);

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_nxt_s;
  logic            kill_r;
  logic            kill_nxt_s;
  logic            hold_load_s;
  logic            hold_clear_s;
  logic            imem_req_s;
  logic [XLEN-1:0] redirect_tgt_s;

  assign redirect_tgt_s = {redirect_pc[XLEN-1:2], 2'b00};

  // FSM decisions; a redirect outranks every other event in every state
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    kill_nxt_s   = kill_r;
    hold_load_s  = 1'b0;
    hold_clear_s = 1'b0;
    imem_req_s   = 1'b0;
    case (state_r)
      ST_BOOT: begin
        if (redirect_valid) pc_nxt_s = redirect_tgt_s;
        else                pc_nxt_s = pc_r;
        state_nxt_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        imem_req_s = ~redirect_valid;
        if (redirect_valid)  pc_nxt_s    = redirect_tgt_s;
        else if (imem_ready) state_nxt_s = ST_WAIT_RSP;
        else                 state_nxt_s = ST_ISSUE;
      end
      ST_WAIT_RSP: begin
        if (imem_rvalid && (kill_r || redirect_valid)) begin
          // Wrong-path data: drop it and refetch from the current pc
          kill_nxt_s  = 1'b0;
          state_nxt_s = ST_ISSUE;
          if (redirect_valid) pc_nxt_s = redirect_tgt_s;
          else                pc_nxt_s = pc_r;
        end else if (imem_rvalid) begin
          hold_load_s = 1'b1;
          pc_nxt_s    = pc_r + PC_STEP;
          state_nxt_s = ST_HOLD;
        end else if (redirect_valid) begin
          pc_nxt_s   = redirect_tgt_s;
          kill_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_RSP;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          hold_clear_s = 1'b1;
          pc_nxt_s     = redirect_tgt_s;
          state_nxt_s  = ST_ISSUE;
        end else if (stall) begin
          state_nxt_s = ST_HOLD;
        end else begin
          hold_clear_s = 1'b1;
          imem_req_s   = 1'b1;
          if (imem_ready) state_nxt_s = ST_WAIT_RSP;
          else            state_nxt_s = ST_ISSUE;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // State, pc and kill registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_BOOT;
      pc_r    <= RESET_PC;
      kill_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      kill_r  <= kill_nxt_s;
    end
  end

  assign imem_req    = imem_req_s;
  assign imem_addr   = pc_r;
  assign if_pc_plus4 = if_pc + PC_STEP;

  fetch_hold_reg #(.XLEN(XLEN)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load_s),
    .clear     (hold_clear_s),
    .load_pc   (pc_r),
    .load_inst (imem_rdata),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst)
  );

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: transaction-level model of the fetch
// stream checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_inst;

  fetch_pc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_inst        (if_inst)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  logic [31:0] acc_q[$];
  logic [31:0] dlv_q[$];
  int          due_q[$];
  logic [31:0] raddr_q[$];

  // Model of the fetch stream in terms of transactions, not FSM states
  logic        m_boot;
  logic        m_out_any;
  logic        m_out_live;
  logic [31:0] m_out_addr;
  logic [31:0] m_next;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        prev_valid;
  logic        exp_req;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC3A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: responds lat cycles after each accepted request
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(raddr_q[0]);
        void'(due_q.pop_front());
        void'(raddr_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;
      end
    end
  end

  // Compare process: mid-cycle check against the model, then advance the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_inst", if_inst, 32'h0000_0013);
        m_boot = 1'b1; m_out_any = 1'b0; m_out_live = 1'b0; m_out_addr = 32'd0;
        m_next = 32'd0; m_valid = 1'b0; m_pc = 32'd0; m_inst = 32'h0000_0013;
        prev_valid = 1'b0;
      end else begin
        exp_req = !m_boot && !redirect_valid && !m_out_any && !(m_valid && stall);
        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check("imem_addr", imem_addr, m_next);
        check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        check("if_pc", if_pc, m_pc);
        check("if_inst", if_inst, m_inst);
        check("if_pc_plus4", if_pc_plus4, m_pc + 32'd4);
        if (imem_req && imem_ready) begin
          acc_q.push_back(imem_addr);
          due_q.push_back(cyc + lat);
          raddr_q.push_back(imem_addr);
        end
        if (if_valid && !prev_valid) dlv_q.push_back(if_pc);
        prev_valid = if_valid;
        if (m_boot) begin
          m_boot = 1'b0;
          if (redirect_valid) m_next = redirect_pc & 32'hFFFF_FFFC;
        end else if (redirect_valid) begin
          m_next  = redirect_pc & 32'hFFFF_FFFC;
          m_valid = 1'b0;
          if (m_out_any) begin
            if (imem_rvalid) m_out_any = 1'b0;
            else             m_out_live = 1'b0;
          end
        end else begin
          if (imem_rvalid && m_out_any) begin
            if (m_out_live) begin
              m_valid = 1'b1;
              m_pc    = m_out_addr;
              m_inst  = imem_rdata;
              m_next  = m_out_addr + 32'd4;
            end
            m_out_any = 1'b0;
          end else if (m_valid && !stall) begin
            m_valid = 1'b0;
          end
          if (exp_req && imem_ready) begin
            m_out_any  = 1'b1;
            m_out_live = 1'b1;
            m_out_addr = m_next;
          end
        end
      end
    end
  end

  task automatic expect_acc(input string name, input int idx, input logic [31:0] exp);
    int n = 0;
    while (acc_q.size() <= idx && n < 200) begin step(); n++; end
    if (acc_q.size() > idx) check(name, acc_q[idx], exp);
    else timeout(name);
  endtask

  task automatic expect_dlv(input string name, input int idx, input logic [31:0] exp);
    int n = 0;
    while (dlv_q.size() <= idx && n < 200) begin step(); n++; end
    if (dlv_q.size() > idx) check(name, dlv_q[idx], exp);
    else timeout(name);
  endtask

  task automatic wait_acc(input string name);
    int a0 = acc_q.size();
    int n  = 0;
    do begin step(); n++; end while (acc_q.size() == a0 && n < 200);
    if (acc_q.size() == a0) timeout(name);
  endtask

  task automatic wait_hold_pc(input string name, input logic [31:0] pc);
    int n = 0;
    while (!(if_valid && if_pc == pc) && n < 200) begin step(); n++; end
    if (!(if_valid && if_pc == pc)) timeout(name);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int na;
    int nd;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    stall = 1'b0; imem_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Straight-line fetch from reset, 1-cycle memory
    expect_acc("boot_addr0", 0, 32'h0);
    expect_acc("boot_addr1", 1, 32'h4);
    expect_acc("boot_addr2", 2, 32'h8);
    expect_dlv("boot_pc0", 0, 32'h0);
    expect_dlv("boot_pc1", 1, 32'h4);
    expect_dlv("boot_pc2", 2, 32'h8);

    // Decode stall in HOLD
    wait_hold_pc("stall_hold", 32'hC);
    stall = 1'b1;
    na = acc_q.size();
    repeat (3) step();
    check("stall_no_req", acc_q.size(), na);
    check("stall_inst", if_inst, 32'hC3A5_000C);
    stall = 1'b0;
    expect_acc("stall_resume", na, 32'h10);

    // Redirect while waiting, response arrives later and must be dropped
    lat = 3;
    wait_acc("kill_acc");
    na = acc_q.size();
    nd = dlv_q.size();
    redirect(32'h100);
    lat = 1;
    expect_acc("kill_next_addr", na, 32'h100);
    expect_dlv("kill_next_pc", nd, 32'h100);

    // Redirect in the same cycle as the response
    lat = 2;
    wait_acc("same_acc");
    na = acc_q.size();
    nd = dlv_q.size();
    step();
    redirect(32'h200);
    lat = 1;
    expect_acc("same_next_addr", na, 32'h200);
    expect_dlv("same_next_pc", nd, 32'h200);

    // Redirect in HOLD while stalled, then an unaligned redirect
    wait_hold_pc("hold_204", 32'h204);
    stall = 1'b1;
    step();
    na = acc_q.size();
    redirect(32'h80);
    check("hold_redirect_valid", {31'd0, if_valid}, 32'd0);
    stall = 1'b0;
    expect_acc("hold_redirect_addr", na, 32'h80);
    wait_hold_pc("hold_84", 32'h84);
    na = acc_q.size();
    redirect(32'h103);
    expect_acc("unaligned_addr", na, 32'h100);

    // Reset while a request is in flight; its late response must be ignored
    lat = 4;
    wait_acc("rst_acc");
    na = acc_q.size();
    nd = dlv_q.size();
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_ready = 1'b0;
    repeat (5) step();
    imem_ready = 1'b1;
    lat = 1;
    expect_acc("rst_first_addr", na, 32'h0);
    expect_dlv("rst_first_pc", nd, 32'h0);

    // PC wrap at the top of the address space
    wait_hold_pc("wrap_4", 32'h4);
    na = acc_q.size();
    redirect(32'hFFFF_FFFC);
    expect_acc("wrap_addr", na, 32'hFFFF_FFFC);
    wait_hold_pc("wrap_hold", 32'hFFFF_FFFC);
    check("wrap_plus4", if_pc_plus4, 32'h0);
    na = acc_q.size();
    expect_acc("wrap_next_addr", na, 32'h0);

    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
